// File: rtl/ccff_loader_pkg.sv
// Shared types, constants and the CRC-8 single-bit update for the
// configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } ccff_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // MSB-first CRC-8: the feedback is the register MSB xor the incoming bit.
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Bit-serial CRC-8 register with synchronous clear and bit enable.
// crc_next_o exposes the value the register takes at the coming edge so the
// owner can compare against it in the same cycle the last bit goes in.
module ccff_crc8
    import ccff_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o,
    output logic [7:0] crc_next_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next value: clear wins over a bit update.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC8_INIT;
        end else if (en_i) begin
            crc_d = crc8_bit(crc_q, bit_i);
        end
    end

    // CRC register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o      = crc_q;
    assign crc_next_o = crc_d;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain from a word stream, LSB first, and
// optionally recirculates the chain once to check its contents by CRC.
//
// Stream handshake: a word transfers on every rising edge where s_valid and
// s_ready are both 1. s_ready depends only on internal state, never on
// s_valid. s_ready is raised in LOAD while the shift register is empty or is
// shifting out its last bit, so back-to-back words shift without a gap, and
// only while chain bits remain to be requested.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err,
    output logic [11:0]       bit_cnt,
    output logic [1:0]        state_dbg
);

    localparam logic [11:0] LAST_BIT = 12'(CHAIN_LEN - 1);
    localparam logic [12:0] LEN13    = 13'(CHAIN_LEN);
    localparam logic [12:0] WORD13   = 13'(WORD_W);

    ccff_state_e       state_q, state_d;
    logic              verify_q, verify_d;
    logic [11:0]       bit_cnt_q, bit_cnt_d;
    logic [12:0]       acc_q, acc_d;          // chain bits already requested
    logic [WORD_W-1:0] sr_q, sr_d;            // word shift register
    logic [5:0]        sr_cnt_q, sr_cnt_d;    // valid bits held in sr_q
    logic              crc_err_q, crc_err_d;

    logic        in_load, in_verify, start_go, load_shift, accept, last_shift;
    logic [12:0] rem_w, take_w;
    logic [7:0]  load_crc, load_crc_next, chk_crc, chk_crc_next;

    assign in_load    = (state_q == ST_LOAD);
    assign in_verify  = (state_q == ST_VERIFY);
    assign start_go   = (state_q == ST_IDLE) && start;
    assign load_shift = in_load && (sr_cnt_q != 6'd0);
    assign s_ready    = in_load && (acc_q < LEN13) && (sr_cnt_q <= 6'd1);
    assign accept     = s_ready && s_valid;
    // The final word is trimmed so no bit beyond the chain is ever shifted.
    assign rem_w      = LEN13 - acc_q;
    assign take_w     = (rem_w < WORD13) ? rem_w : WORD13;

    assign ccff_shift_en = load_shift || in_verify;
    assign ccff_head     = in_verify ? ccff_tail : (load_shift & sr_q[0]);
    assign last_shift    = ccff_shift_en && (bit_cnt_q == LAST_BIT);

    assign busy      = in_load || in_verify;
    assign done      = (state_q == ST_DONE);
    assign crc_err   = crc_err_q;
    assign bit_cnt   = bit_cnt_q;
    assign state_dbg = state_q;

    // Phase sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (last_shift) state_d = verify_q ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (last_shift) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: word intake, shifting, counters and the error flag.
    always_comb begin
        verify_d  = verify_q;
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        sr_cnt_d  = sr_cnt_q;
        crc_err_d = crc_err_q;
        if (start_go) begin
            verify_d  = verify_en;
            bit_cnt_d = 12'd0;
            acc_d     = 13'd0;
            sr_d      = '0;
            sr_cnt_d  = 6'd0;
            crc_err_d = 1'b0;
        end else begin
            if (accept) begin
                sr_d     = s_data;
                sr_cnt_d = take_w[5:0];
                acc_d    = acc_q + take_w;
            end else if (load_shift) begin
                sr_d     = sr_q >> 1;
                sr_cnt_d = sr_cnt_q - 6'd1;
            end
            // The count restarts for the recirculate phase.
            if (in_load && last_shift && verify_q) begin
                bit_cnt_d = 12'd0;
            end else if (ccff_shift_en) begin
                bit_cnt_d = bit_cnt_q + 12'd1;
            end
            if (in_verify && last_shift && (chk_crc_next != load_crc)) begin
                crc_err_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= ST_IDLE;
            verify_q  <= 1'b0;
            bit_cnt_q <= 12'd0;
            acc_q     <= 13'd0;
            sr_q      <= '0;
            sr_cnt_q  <= 6'd0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            verify_q  <= verify_d;
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            sr_cnt_q  <= sr_cnt_d;
            crc_err_q <= crc_err_d;
        end
    end

    ccff_crc8 u_load_crc (
        .clk_i      (prog_clk),
        .rst_i      (pReset),
        .clr_i      (start_go),
        .en_i       (load_shift),
        .bit_i      (sr_q[0]),
        .crc_o      (load_crc),
        .crc_next_o (load_crc_next)
    );

    ccff_crc8 u_chk_crc (
        .clk_i      (prog_clk),
        .rst_i      (pReset),
        .clr_i      (start_go),
        .en_i       (in_verify),
        .bit_i      (ccff_tail),
        .crc_o      (chk_crc),
        .crc_next_o (chk_crc_next)
    );

    // load_crc_next and chk_crc are not needed beyond the comparison above.
    logic unused_crc;
    assign unused_crc = ^{load_crc_next, chk_crc};

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a behavioural chain drives ccff_tail, a queue
// of expected head bits is built from the words, and each scenario task
// checks timing, handshake and CRC outcome inline.
module tb_ccff_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    logic          prog_clk = 1'b0;
    logic          pReset, start, verify_en, s_valid;
    logic [WW-1:0] s_data;
    logic          s_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic          busy, done, crc_err;
    logic [11:0]   bit_cnt;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural chain: head enters bit 0, tail is the oldest bit.
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] snap  = '0;
    bit            flip_en = 1'b0;
    int            epoch = 0, seen_epoch = 0, shifts_seen = 0;

    logic [WW-1:0] words[NW];
    int            gaps[NW];
    logic [0:0]    exp_q[$];

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .verify_en     (verify_en),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .crc_err       (crc_err),
        .bit_cnt       (bit_cnt),
        .state_dbg     (state_dbg)
    );

    // Clock and cycle counter.
    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    assign ccff_tail = chain[CL-1];

    // Chain model; optionally corrupts bit 7 right after the CL-th load shift.
    always @(posedge prog_clk) begin
        logic [CL-1:0] nxt;
        if (seen_epoch != epoch) begin
            seen_epoch  = epoch;
            shifts_seen = 0;
        end
        if (ccff_shift_en) begin
            nxt = {chain[CL-2:0], ccff_head};
            shifts_seen++;
            if (flip_en && shifts_seen == CL) nxt[7] = ~nxt[7];
            if (shifts_seen == CL) snap = nxt;
            chain <= nxt;
        end
    end

    task automatic test_reset();
        pReset = 1'b1; start = 1'b0; verify_en = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge prog_clk);
        n_cmp++; if (s_ready !== 1'b0)       begin n_err++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
        n_cmp++; if (ccff_head !== 1'b0)     begin n_err++; $display("FAIL rst_head got %b want 0", ccff_head); end
        n_cmp++; if (ccff_shift_en !== 1'b0) begin n_err++; $display("FAIL rst_shift_en got %b want 0", ccff_shift_en); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)          begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (crc_err !== 1'b0)       begin n_err++; $display("FAIL rst_crc_err got %b want 0", crc_err); end
        n_cmp++; if (bit_cnt !== 12'd0)      begin n_err++; $display("FAIL rst_bit_cnt got %0d want 0", bit_cnt); end
        n_cmp++; if (state_dbg !== 2'd0)     begin n_err++; $display("FAIL rst_state got %0d want 0", state_dbg); end
        pReset = 1'b0;
        @(negedge prog_clk);
    endtask

    // One complete load (and optional verify) with per-word stall gaps.
    task automatic run_load(input string nm, input bit ver, input bit flip, input bit spur);
        int            g_tot, ld_end, d_off, wi, gap_left, n_shift, n_done;
        logic [CL-1:0] bits, exp_chain;
        logic [0:0]    e;
        bit            exp_err;
        g_tot = 0;
        foreach (gaps[i]) g_tot += gaps[i];
        exp_q.delete();
        for (int i = 0; i < CL; i++) begin
            bits[i] = words[i / WW][i % WW];
            exp_chain[CL-1-i] = bits[i];
            exp_q.push_back(bits[i]);
        end
        ld_end  = CL + 2 + g_tot;
        d_off   = ver ? ld_end + CL : ld_end;
        exp_err = ver && flip;
        flip_en = flip;
        @(negedge prog_clk);
        start = 1'b1; verify_en = ver; s_valid = 1'b0; epoch++;
        wi = 0; gap_left = gaps[0]; n_shift = 0; n_done = 0;
        for (int k = 1; k <= d_off + 2; k++) begin
            @(negedge prog_clk);
            start     = spur && (k == 5 || k == d_off);
            verify_en = 1'($urandom_range(0, 1));
            n_cmp++; if (busy !== (k < d_off)) begin n_err++; $display("FAIL %s busy k=%0d got %b want %b", nm, k, busy, k < d_off); end
            n_cmp++; if (done !== (k == d_off)) begin n_err++; $display("FAIL %s done k=%0d got %b want %b", nm, k, done, k == d_off); end
            if (done === 1'b1) n_done++;
            if (k >= ld_end) begin
                n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL %s s_ready k=%0d got %b want 0", nm, k, s_ready); end
            end
            if (k >= d_off) begin
                n_cmp++; if (ccff_shift_en !== 1'b0) begin n_err++; $display("FAIL %s shift_en k=%0d got %b want 0", nm, k, ccff_shift_en); end
            end
            n_cmp++;
            if (crc_err !== ((k >= d_off) ? exp_err : 1'b0)) begin
                n_err++; $display("FAIL %s crc_err k=%0d got %b want %b", nm, k, crc_err, (k >= d_off) ? exp_err : 1'b0);
            end
            if (ccff_shift_en === 1'b1) begin
                n_shift++;
                if (k < ld_end) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL %s extra_load_shift k=%0d got shift want none", nm, k);
                    end else begin
                        e = exp_q.pop_front();
                        if (ccff_head !== e) begin n_err++; $display("FAIL %s head k=%0d got %b want %b", nm, k, ccff_head, e); end
                    end
                end else begin
                    n_cmp++; if (ccff_head !== ccff_tail) begin n_err++; $display("FAIL %s recirc k=%0d got %b want %b", nm, k, ccff_head, ccff_tail); end
                end
            end
            if (k == d_off) begin
                n_cmp++; if (bit_cnt !== 12'(CL)) begin n_err++; $display("FAIL %s bit_cnt got %0d want %0d", nm, bit_cnt, CL); end
                if (ver) begin
                    n_cmp++; if (chain !== snap) begin n_err++; $display("FAIL %s chain_restored got %h want %h", nm, chain, snap); end
                end
                if (!flip) begin
                    n_cmp++; if (chain !== exp_chain) begin n_err++; $display("FAIL %s chain_contents got %h want %h", nm, chain, exp_chain); end
                end
            end
            // Drive the stream for the coming edge.
            if (s_ready === 1'b1 && wi < NW) begin
                if (gap_left > 0) begin
                    s_valid = 1'b0; gap_left--;
                end else begin
                    s_valid = 1'b1; s_data = words[wi]; wi++;
                    gap_left = (wi < NW) ? gaps[wi] : 0;
                end
            end else begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = WW'($urandom);
            end
        end
        start = 1'b0; s_valid = 1'b0;
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL %s done_count got %0d want 1", nm, n_done); end
        n_cmp++; if (n_shift != (ver ? 2 * CL : CL)) begin n_err++; $display("FAIL %s shift_count got %0d want %0d", nm, n_shift, ver ? 2 * CL : CL); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL %s missing_shifts got %0d left want 0", nm, exp_q.size()); end
        flip_en = 1'b0;
    endtask

    task automatic test_load_basic();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
        foreach (gaps[i]) gaps[i] = 0;
        run_load("load_basic", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_gaps();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
        gaps[0] = 0; gaps[1] = 5; gaps[2] = 0;
        run_load("load_gaps", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_verify_ok();
        foreach (words[i]) words[i] = WW'($urandom);
        foreach (gaps[i]) gaps[i] = 0;
        run_load("verify_ok", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_verify_flip();
        foreach (words[i]) words[i] = WW'($urandom);
        foreach (gaps[i]) gaps[i] = 0;
        run_load("verify_flip", 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge prog_clk);
            n_cmp++; if (crc_err !== 1'b1) begin n_err++; $display("FAIL sticky_err k=%0d got %b want 1", k, crc_err); end
        end
        // The next load starts with crc_err cleared (checked inside run_load).
        foreach (words[i]) words[i] = WW'($urandom);
        run_load("after_flip", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n_sh, wi, k;
        @(negedge prog_clk);
        start = 1'b1; verify_en = 1'b1; epoch++;
        n_sh = 0; wi = 0; k = 0;
        while (n_sh < 10 && k < 40) begin
            @(negedge prog_clk);
            k++;
            start = 1'b0;
            if (ccff_shift_en === 1'b1) n_sh++;
            s_valid = 1'b1;
            s_data  = WW'($urandom);
        end
        n_cmp++; if (n_sh != 10) begin n_err++; $display("FAIL rmid_reach got %0d shifts want 10", n_sh); end
        pReset = 1'b1; s_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b0;
        n_cmp++; if (ccff_shift_en !== 1'b0) begin n_err++; $display("FAIL rmid_shift_en got %b want 0", ccff_shift_en); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)          begin n_err++; $display("FAIL rmid_done got %b want 0", done); end
        n_cmp++; if (state_dbg !== 2'd0)     begin n_err++; $display("FAIL rmid_state got %0d want 0", state_dbg); end
        n_cmp++; if (bit_cnt !== 12'd0)      begin n_err++; $display("FAIL rmid_bit_cnt got %0d want 0", bit_cnt); end
        for (int j = 0; j < 30; j++) begin
            @(negedge prog_clk);
            s_valid = 1'($urandom_range(0, 1));
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle j=%0d got done=%b busy=%b want 0 0", j, done, busy); end
        end
        foreach (words[i]) words[i] = WW'($urandom);
        foreach (gaps[i]) gaps[i] = 0;
        run_load("after_reset", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_start();
        foreach (words[i]) words[i] = WW'($urandom);
        foreach (gaps[i]) gaps[i] = 0;
        run_load("spurious", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit v, f;
        for (int r = 0; r < 6; r++) begin
            foreach (words[i]) words[i] = WW'($urandom);
            foreach (gaps[i]) gaps[i] = $urandom_range(0, 4);
            v = 1'($urandom_range(0, 1));
            f = v && 1'($urandom_range(0, 1));
            run_load("random", v, f, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_gaps();
        test_verify_ok();
        test_verify_flip();
        test_reset_mid();
        test_spurious_start();
        test_random();
        repeat (2) @(negedge prog_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
